combo_lock_param: RTL and testbench

COMBO_LOCK_PARAM -- requirements
Module: combo_lock_param

---
 rtl/combo_lock_param.sv | 165 ++++++++++++++++
 tb/tb_combo_lock_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_param.sv
// Parameterised combination lock: digits are entered serially and compared against a
// loadable code, with a failed-attempt counter that latches a lockout after MAX_TRIES.
module combo_lock_param #(
   parameter int unsigned          DIGITS       = 6,
   parameter int unsigned          DW           = 4,
   parameter int unsigned          MAX_TRIES    = 3,
   parameter logic [DIGITS*DW-1:0] DEFAULT_CODE = 24'h234528
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [DW-1:0]                    digit_in,
   input  logic                             enter,
   input  logic                             clear,
   input  logic                             code_load,
   input  logic [DIGITS*DW-1:0]             code_in,
   output logic [2:0]                       state,
   output logic [$clog2(DIGITS+1)-1:0]      pos,
   output logic                             unlocked,
   output logic                             fail,
   output logic                             locked_out,
   output logic [$clog2(MAX_TRIES+1)-1:0]   fails
);

   localparam int unsigned PW = $clog2(DIGITS + 1);
   localparam int unsigned FW = $clog2(MAX_TRIES + 1);
   localparam int unsigned CW = DIGITS * DW;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_OPEN    = 3'd2,
      S_FAIL    = 3'd3,
      S_LOCKOUT = 3'd4
   } state_e;

   state_e          state_q, state_n;
   logic [PW-1:0]   pos_q, pos_n;
   logic            mm_q, mm_n;
   logic [FW-1:0]   fails_q, fails_n;
   logic [CW-1:0]   code_q, code_n;
   logic [DW-1:0]   cur_digit;
   logic            digit_bad;
   logic            mm_acc;
   logic            unlocked_n, fail_n, locked_out_n;
   logic            unlocked_q, fail_q, locked_out_q;

   // Code digit expected at the current position (pos is 0 in IDLE, so this is digit 0 there).
   always_comb begin
      cur_digit = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (pos_q == PW'(i)) cur_digit = code_q[DW*i +: DW];
      end
      digit_bad = (digit_in != cur_digit);
      mm_acc    = mm_q | digit_bad;
   end

   // State register; all outputs are flops updated from the next-state values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pos_q        <= '0;
         mm_q         <= 1'b0;
         fails_q      <= '0;
         code_q       <= DEFAULT_CODE;
         unlocked_q   <= 1'b0;
         fail_q       <= 1'b0;
         locked_out_q <= 1'b0;
      end else begin
         state_q      <= state_n;
         pos_q        <= pos_n;
         mm_q         <= mm_n;
         fails_q      <= fails_n;
         code_q       <= code_n;
         unlocked_q   <= unlocked_n;
         fail_q       <= fail_n;
         locked_out_q <= locked_out_n;
      end
   end

   // Next-state logic; priority inside each state is code_load > clear > enter.
   always_comb begin
      state_n = state_q;
      pos_n   = pos_q;
      mm_n    = mm_q;
      fails_n = fails_q;
      code_n  = code_q;
      unique case (state_q)
         S_IDLE: begin
            if (code_load) begin
               code_n = code_in;
               pos_n  = '0;
               mm_n   = 1'b0;
            end else if (enter) begin
               state_n = S_ENTRY;
               pos_n   = PW'(1);
               mm_n    = digit_bad;
            end
         end
         S_ENTRY: begin
            if (clear) begin
               state_n = S_IDLE;
               pos_n   = '0;
               mm_n    = 1'b0;
            end else if (enter) begin
               pos_n = pos_q + PW'(1);
               mm_n  = mm_acc;
               if (pos_q == PW'(DIGITS - 1)) begin
                  if (!mm_acc) begin
                     state_n = S_OPEN;
                  end else begin
                     fails_n = fails_q + FW'(1);
                     state_n = (fails_n == FW'(MAX_TRIES)) ? S_LOCKOUT : S_FAIL;
                  end
               end
            end
         end
         S_OPEN: begin
            if (code_load) begin
               code_n  = code_in;
               state_n = S_IDLE;
               pos_n   = '0;
               mm_n    = 1'b0;
            end else if (clear) begin
               state_n = S_IDLE;
               pos_n   = '0;
               mm_n    = 1'b0;
               fails_n = '0;
            end
         end
         S_FAIL: begin
            if (clear) begin
               state_n = S_IDLE;
               pos_n   = '0;
               mm_n    = 1'b0;
            end
         end
         S_LOCKOUT: begin
            state_n = S_LOCKOUT;
         end
         default: begin
            state_n = S_IDLE;
            pos_n   = '0;
            mm_n    = 1'b0;
         end
      endcase
   end

   // Status flags decoded from the next state so they align with the state register.
   always_comb begin
      unlocked_n   = 1'b0;
      fail_n       = 1'b0;
      locked_out_n = 1'b0;
      unlocked_n   = (state_n == S_OPEN);
      fail_n       = (state_n == S_FAIL);
      locked_out_n = (state_n == S_LOCKOUT);
   end

   assign state      = state_q;
   assign pos        = pos_q;
   assign fails      = fails_q;
   assign unlocked   = unlocked_q;
   assign fail       = fail_q;
   assign locked_out = locked_out_q;

endmodule

// File: tb/tb_combo_lock_param.sv
// Directed bench for combo_lock_param: a driver queues hand-computed expectations and a
// monitor compares them one cycle later, just after each rising edge.
module tb_combo_lock_param;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  digit_in = '0;
   logic        enter = 1'b0;
   logic        clear = 1'b0;
   logic        code_load = 1'b0;
   logic [23:0] code_in = '0;
   logic [2:0]  state;
   logic [2:0]  pos;
   logic        unlocked, fail, locked_out;
   logic [1:0]  fails;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      logic [2:0] st;
      logic [2:0] ps;
      logic       ul;
      logic       fl;
      logic       lo;
      logic [1:0] fc;
   } exp_t;

   exp_t exp_q[$];

   combo_lock_param dut (
      .clk        (clk),
      .reset      (reset),
      .digit_in   (digit_in),
      .enter      (enter),
      .clear      (clear),
      .code_load  (code_load),
      .code_in    (code_in),
      .state      (state),
      .pos        (pos),
      .unlocked   (unlocked),
      .fail       (fail),
      .locked_out (locked_out),
      .fails      (fails)
   );

   always #5 clk = ~clk;

   // Monitor: every edge the DUT presents a new output set; compare it against the queue head.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (state !== e.st || pos !== e.ps || unlocked !== e.ul || fail !== e.fl ||
             locked_out !== e.lo || fails !== e.fc) begin
            errors++;
            $display("FAIL %s: got state=%0d pos=%0d unl=%0b fail=%0b lo=%0b fails=%0d, want state=%0d pos=%0d unl=%0b fail=%0b lo=%0b fails=%0d",
                     e.name, state, pos, unlocked, fail, locked_out, fails,
                     e.st, e.ps, e.ul, e.fl, e.lo, e.fc);
         end
      end
   end

   task automatic step(input string nm, input logic r, input logic e, input logic [3:0] d,
                       input logic c, input logic ld, input logic [23:0] ci,
                       input logic [2:0] es, input logic [2:0] ep, input logic [1:0] ef);
      exp_t x;
      @(negedge clk);
      reset = r; enter = e; digit_in = d; clear = c; code_load = ld; code_in = ci;
      x.name = nm; x.st = es; x.ps = ep; x.fc = ef;
      x.ul = (es == 3'd2); x.fl = (es == 3'd3); x.lo = (es == 3'd4);
      exp_q.push_back(x);
   endtask

   task automatic ent(input string nm, input logic [3:0] d,
                      input logic [2:0] es, input logic [2:0] ep, input logic [1:0] ef);
      step(nm, 1'b0, 1'b1, d, 1'b0, 1'b0, 24'h0, es, ep, ef);
   endtask

   task automatic clr(input string nm, input logic [2:0] es, input logic [2:0] ep,
                      input logic [1:0] ef);
      step(nm, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 24'h0, es, ep, ef);
   endtask

   task automatic rst(input string nm);
      step(nm, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 24'h0, 3'd0, 3'd0, 2'd0);
   endtask

   initial begin
      rst("reset0");
      rst("reset1");
      step("idle", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 24'h0, 3'd0, 3'd0, 2'd0);
      clr("idle_clear", 3'd0, 3'd0, 2'd0);

      // Correct default code 8,2,5,4,3,2
      ent("ok_d0", 4'd8, 3'd1, 3'd1, 2'd0);
      ent("ok_d1", 4'd2, 3'd1, 3'd2, 2'd0);
      ent("ok_d2", 4'd5, 3'd1, 3'd3, 2'd0);
      ent("ok_d3", 4'd4, 3'd1, 3'd4, 2'd0);
      ent("ok_d4", 4'd3, 3'd1, 3'd5, 2'd0);
      ent("ok_d5", 4'd2, 3'd2, 3'd6, 2'd0);
      ent("open_enter_ignored", 4'd7, 3'd2, 3'd6, 2'd0);
      clr("open_clear", 3'd0, 3'd0, 2'd0);

      // One wrong digit in the middle
      ent("bad1_d0", 4'd8, 3'd1, 3'd1, 2'd0);
      ent("bad1_d1", 4'd2, 3'd1, 3'd2, 2'd0);
      ent("bad1_d2", 4'd0, 3'd1, 3'd3, 2'd0);
      ent("bad1_d3", 4'd4, 3'd1, 3'd4, 2'd0);
      ent("bad1_d4", 4'd3, 3'd1, 3'd5, 2'd0);
      ent("bad1_d5", 4'd2, 3'd3, 3'd6, 2'd1);
      ent("fail_enter_ignored", 4'd8, 3'd3, 3'd6, 2'd1);
      step("fail_load_ignored", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 24'h111111, 3'd3, 3'd6, 2'd1);
      clr("fail_clear", 3'd0, 3'd0, 2'd1);
      clr("idle_clear2", 3'd0, 3'd0, 2'd1);

      // Abort at pos=3, then enter+clear together
      ent("ab_d0", 4'd8, 3'd1, 3'd1, 2'd1);
      ent("ab_d1", 4'd2, 3'd1, 3'd2, 2'd1);
      ent("ab_d2", 4'd5, 3'd1, 3'd3, 2'd1);
      step("entry_load_ignored", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 24'h111111, 3'd1, 3'd3, 2'd1);
      clr("abort_pos3", 3'd0, 3'd0, 2'd1);
      ent("ec_d0", 4'd8, 3'd1, 3'd1, 2'd1);
      step("enter_clear_same", 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 24'h0, 3'd0, 3'd0, 2'd1);

      // Second and third wrong entries -> lockout
      for (int i = 0; i < 5; i++) ent("bad2_d", 4'd1, 3'd1, 3'(i + 1), 2'd1);
      ent("bad2_last", 4'd1, 3'd3, 3'd6, 2'd2);
      clr("bad2_clear", 3'd0, 3'd0, 2'd2);
      for (int i = 0; i < 5; i++) ent("bad3_d", 4'd9, 3'd1, 3'(i + 1), 2'd2);
      ent("bad3_last", 4'd9, 3'd4, 3'd6, 2'd3);
      clr("lock_clear_ignored", 3'd4, 3'd6, 2'd3);
      ent("lock_enter_ignored", 4'd8, 3'd4, 3'd6, 2'd3);
      step("lock_load_ignored", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 24'h654321, 3'd4, 3'd6, 2'd3);
      rst("lock_reset");

      // Default code still in place after lockout; open then reload a new code
      ent("ok2_d0", 4'd8, 3'd1, 3'd1, 2'd0);
      ent("ok2_d1", 4'd2, 3'd1, 3'd2, 2'd0);
      ent("ok2_d2", 4'd5, 3'd1, 3'd3, 2'd0);
      ent("ok2_d3", 4'd4, 3'd1, 3'd4, 2'd0);
      ent("ok2_d4", 4'd3, 3'd1, 3'd5, 2'd0);
      ent("ok2_d5", 4'd2, 3'd2, 3'd6, 2'd0);
      step("open_load_beats_clear", 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 24'h654321, 3'd0, 3'd0, 2'd0);
      for (int i = 0; i < 5; i++) ent("new_d", 4'(i + 1), 3'd1, 3'(i + 1), 2'd0);
      ent("new_last", 4'd6, 3'd2, 3'd6, 2'd0);
      clr("new_open_clear", 3'd0, 3'd0, 2'd0);
      ent("old_d0", 4'd8, 3'd1, 3'd1, 2'd0);
      ent("old_d1", 4'd2, 3'd1, 3'd2, 2'd0);
      ent("old_d2", 4'd5, 3'd1, 3'd3, 2'd0);
      ent("old_d3", 4'd4, 3'd1, 3'd4, 2'd0);
      ent("old_d4", 4'd3, 3'd1, 3'd5, 2'd0);
      ent("old_last", 4'd2, 3'd3, 3'd6, 2'd1);
      clr("old_clear", 3'd0, 3'd0, 2'd1);

      // Successful open keeps fails until clear, which zeroes it
      for (int i = 0; i < 5; i++) ent("re_d", 4'(i + 1), 3'd1, 3'(i + 1), 2'd1);
      ent("re_last", 4'd6, 3'd2, 3'd6, 2'd1);
      clr("re_clear_zero_fails", 3'd0, 3'd0, 2'd0);

      // code_load beats enter in IDLE (loads the default back), then reset mid-entry
      step("idle_load_beats_enter", 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 24'h234528, 3'd0, 3'd0, 2'd0);
      ent("mid_d0", 4'd8, 3'd1, 3'd1, 2'd0);
      ent("mid_d1", 4'd2, 3'd1, 3'd2, 2'd0);
      step("mid_reset_with_enter", 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 24'h0, 3'd0, 3'd0, 2'd0);
      step("reset_hold", 1'b1, 1'b1, 4'd8, 1'b0, 1'b0, 24'h0, 3'd0, 3'd0, 2'd0);
      ent("post_d0", 4'd8, 3'd1, 3'd1, 2'd0);

      @(negedge clk);
      enter = 1'b0; clear = 1'b0; code_load = 1'b0; reset = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
